// File: rtl/mmio_channel_fifo_if.sv
// Bus and drain signals of the MMIO channel FIFO: CPU load/store port plus per-channel valid/ready.
// The master side is the CPU and the downstream consumers; the slave side is the peripheral.
interface mmio_channel_fifo_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0]        bus_addr;
  logic [DATA_W-1:0]        bus_wr_data;
  logic                     bus_wr_en;
  logic                     bus_rd_en;
  logic [DATA_W-1:0]        bus_rd_data;
  logic                     bus_hit;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;

  modport master (
    output bus_addr, bus_wr_data, bus_wr_en, bus_rd_en, out_ready,
    input  bus_rd_data, bus_hit, out_data, out_valid
  );

  modport slave (
    input  bus_addr, bus_wr_data, bus_wr_en, bus_rd_en, out_ready,
    output bus_rd_data, bus_hit, out_data, out_valid
  );
endinterface

// File: rtl/mmio_channel_fifo.sv
// Memory-mapped write queue: NUM_CH store-fed FIFOs drained over valid/ready, plus a status word.
// Optional sticky overflow flags are enabled by defining MMIO_OVERFLOW_STICKY_EN.
module mmio_channel_fifo #(
  parameter int                NUM_CH    = 4,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00
) (
  input logic                CLK_50MHZ,
  input logic                reset,
  mmio_channel_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit keeps the window compare correct when the window touches the top of the map.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(NUM_CH);

  logic                     hit;
  logic [ADDR_W-1:0]        offset;
  logic                     statusSel;
  logic [NUM_CH-1:0]        chSel;
  logic [NUM_CH-1:0]        empty;
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        overflow;
  logic [NUM_CH-1:0]        outValid;
  logic [NUM_CH*DATA_W-1:0] outData;
  logic [DATA_W-1:0]        statusWord;
  logic [DATA_W-1:0]        rdDataReg;

  assign hit       = ({1'b0, bus.bus_addr} >= WIN_LO) && ({1'b0, bus.bus_addr} <= WIN_HI);
  assign offset    = bus.bus_addr - BASE_ADDR;
  assign statusSel = hit && (offset == ADDR_W'(NUM_CH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gCh
      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  wrPtrReg;
      logic [PTR_W-1:0]  rdPtrReg;
      logic [CNT_W-1:0]  countReg;
      logic              push;
      logic              pop;

      assign chSel[gi] = hit && (offset == ADDR_W'(gi));
      assign empty[gi] = (countReg == '0);
      assign full[gi]  = (countReg == CNT_W'(DEPTH));
      // Full is judged on the pre-edge count, so a same-cycle pop cannot make room for a store.
      assign push      = bus.bus_wr_en && chSel[gi] && !full[gi];
      assign pop       = !empty[gi] && bus.out_ready[gi];

      always_ff @(posedge CLK_50MHZ) begin
        if (reset) begin
          wrPtrReg <= '0;
          rdPtrReg <= '0;
          countReg <= '0;
        end else begin
          if (push) wrPtrReg <= wrPtrReg + PTR_W'(1);
          if (pop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
          if (push && !pop)      countReg <= countReg + CNT_W'(1);
          else if (pop && !push) countReg <= countReg - CNT_W'(1);
        end
      end

      // Storage is never cleared; the pointers alone define what is live.
      always_ff @(posedge CLK_50MHZ) begin
        if (push && !reset) mem[wrPtrReg] <= bus.bus_wr_data;
      end

      assign outData[gi*DATA_W +: DATA_W] = mem[rdPtrReg];
      assign outValid[gi]                 = !empty[gi];

`ifdef MMIO_OVERFLOW_STICKY_EN
      logic ovfReg;
      logic ovfSet;
      logic ovfClr;

      assign ovfSet = bus.bus_wr_en && chSel[gi] && full[gi];
      assign ovfClr = bus.bus_wr_en && statusSel && bus.bus_wr_data[2*NUM_CH+gi];

      always_ff @(posedge CLK_50MHZ) begin
        if (reset)       ovfReg <= 1'b0;
        else if (ovfSet) ovfReg <= 1'b1;
        else if (ovfClr) ovfReg <= 1'b0;
      end

      assign overflow[gi] = ovfReg;
`else
      assign overflow[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    statusWord                          = '0;
    statusWord[NUM_CH-1:0]              = empty;
    statusWord[2*NUM_CH-1:NUM_CH]       = full;
    statusWord[3*NUM_CH-1:2*NUM_CH]     = overflow;
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (reset)              rdDataReg <= '0;
    else if (bus.bus_rd_en) rdDataReg <= statusSel ? statusWord : '0;
  end

  assign bus.bus_hit     = hit;
  assign bus.bus_rd_data = rdDataReg;
  assign bus.out_data    = outData;
  assign bus.out_valid   = outValid;
endmodule

// File: tb/tb_mmio_channel_fifo.sv
// Directed bench for mmio_channel_fifo: queue-based reference model compared every cycle,
// plus hand-computed literal checks at key points of each scenario.
module tb_mmio_channel_fifo;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mmio_channel_fifo_if #(.NUM_CH(4), .DATA_W(16), .ADDR_W(16)) bus ();

  mmio_channel_fifo #(
    .NUM_CH(4), .DATA_W(16), .ADDR_W(16), .DEPTH(8), .BASE_ADDR(16'hFF00)
  ) dut (
    .CLK_50MHZ(clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel, sticky flags, expected load data.
  logic [15:0] mq [4][$];
  bit          mOvf [4];
  logic [15:0] mRd = 16'h0000;
  bit          started = 1'b0;

  function automatic logic [15:0] modelStatus();
    logic [15:0] s;
    s = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      s[k]     = (mq[k].size() == 0);
      s[4 + k] = (mq[k].size() == 8);
      s[8 + k] = mOvf[k];
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      logic [15:0] st;
      bit          sel;
      @(posedge clk);
      if (reset) begin
        for (int k = 0; k < 4; k++) begin
          mq[k].delete();
          mOvf[k] = 1'b0;
        end
        mRd     = 16'h0000;
        started = 1'b1;
      end else begin
        st = modelStatus();
        if (bus.bus_rd_en) mRd = (bus.bus_addr == 16'hFF04) ? st : 16'h0000;
        for (int k = 0; k < 4; k++) begin
          sel = bus.bus_wr_en && (bus.bus_addr == 16'(32'hFF00 + k));
`ifdef MMIO_OVERFLOW_STICKY_EN
          if (sel && st[4 + k]) mOvf[k] = 1'b1;
          else if (bus.bus_wr_en && bus.bus_addr == 16'hFF04 && bus.bus_wr_data[8 + k]) mOvf[k] = 1'b0;
`endif
          if (!st[k] && bus.out_ready[k]) void'(mq[k].pop_front());
          if (sel && !st[4 + k]) mq[k].push_back(bus.bus_wr_data);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  initial begin
    forever begin
      logic [3:0] expValid;
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 4; k++) begin
          expValid[k] = (mq[k].size() != 0);
          if (mq[k].size() != 0)
            check($sformatf("cyc_data%0d", k), 64'(bus.out_data[k*16 +: 16]), 64'(mq[k][0]));
        end
        check("cyc_valid", 64'(bus.out_valid), 64'(expValid));
        check("cyc_rddata", 64'(bus.bus_rd_data), 64'(mRd));
        check("cyc_hit", 64'(bus.bus_hit),
              64'(bus.bus_addr >= 16'hFF00 && bus.bus_addr <= 16'hFF04));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    bus.bus_addr    = a;
    bus.bus_wr_data = d;
    bus.bus_wr_en   = 1'b1;
    tick();
    bus.bus_wr_en   = 1'b0;
    $display("store addr=%h data=%h", a, d);
  endtask

  task automatic load(input logic [15:0] a);
    bus.bus_addr  = a;
    bus.bus_rd_en = 1'b1;
    tick();
    bus.bus_rd_en = 1'b0;
    $display("load  addr=%h data=%h", a, bus.bus_rd_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] last;
    reset           = 1'b1;
    bus.bus_addr    = 16'h0000;
    bus.bus_wr_data = 16'h0000;
    bus.bus_wr_en   = 1'b0;
    bus.bus_rd_en   = 1'b0;
    bus.out_ready   = 4'b0000;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    load(16'hFF04);
    check("t1_status", 64'(bus.bus_rd_data), 64'h000F);
    check("t1_valid", 64'(bus.out_valid), 64'h0);

    // Single store, visible next cycle, drained by one ready cycle
    store(16'hFF01, 16'h0041);
    check("t2_valid", 64'(bus.out_valid), 64'b0010);
    check("t2_data", 64'(bus.out_data[31:16]), 64'h0041);
    bus.out_ready = 4'b0010;
    tick();
    bus.out_ready = 4'b0000;
    check("t2_drained", 64'(bus.out_valid), 64'h0);
    load(16'hFF01);
    check("t2_chload", 64'(bus.bus_rd_data), 64'h0);

    // Nine stores into an 8-deep channel, then in-order drain
    for (int i = 1; i <= 9; i++) store(16'hFF00, 16'(i));
    load(16'hFF04);
`ifdef MMIO_OVERFLOW_STICKY_EN
    check("t3_status", 64'(bus.bus_rd_data), 64'h011E);
`else
    check("t3_status", 64'(bus.bus_rd_data), 64'h001E);
`endif
    bus.out_ready = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      check("t3_drain", 64'(bus.out_data[15:0]), 64'(i));
      tick();
    end
    bus.out_ready = 4'b0000;
    check("t3_empty", 64'(bus.out_valid[0]), 64'h0);
    store(16'hFF00, 16'h00A5);
    check("t3_wrap", 64'(bus.out_data[15:0]), 64'h00A5);
    bus.out_ready = 4'b0001;
    tick();
    bus.out_ready = 4'b0000;

    // Push while full plus pop: store rejected; push and pop at count 3: both happen
    for (int i = 0; i < 8; i++) store(16'hFF02, 16'(16'h0200 + i));
    bus.out_ready = 4'b0100;
    store(16'hFF02, 16'hAAAA);
    bus.out_ready = 4'b0000;
    check("t4_head", 64'(bus.out_data[47:32]), 64'h0201);
    load(16'hFF04);
`ifdef MMIO_OVERFLOW_STICKY_EN
    check("t4_status", 64'(bus.bus_rd_data), 64'h050B);
`else
    check("t4_status", 64'(bus.bus_rd_data), 64'h000B);
`endif
    bus.out_ready = 4'b0100;
    repeat (4) tick();
    bus.out_ready = 4'b0000;
    check("t4_head3", 64'(bus.out_data[47:32]), 64'h0205);
    bus.out_ready = 4'b0100;
    store(16'hFF02, 16'hAAAA);
    bus.out_ready = 4'b0000;
    check("t4_head_after", 64'(bus.out_data[47:32]), 64'h0206);
    bus.out_ready = 4'b0100;
    last = 16'h0000;
    for (int j = 0; j < 3; j++) begin
      last = bus.out_data[47:32];
      tick();
    end
    bus.out_ready = 4'b0000;
    check("t4_last", 64'(last), 64'hAAAA);
    check("t4_empty", 64'(bus.out_valid[2]), 64'h0);

    // Reset mid-operation with a pending store and load
    for (int i = 0; i < 5; i++) store(16'hFF03, 16'(16'h0300 + i));
    bus.bus_addr    = 16'hFF03;
    bus.bus_wr_data = 16'hDEAD;
    bus.bus_wr_en   = 1'b1;
    bus.bus_rd_en   = 1'b1;
    bus.out_ready   = 4'b1000;
    reset           = 1'b1;
    tick();
    reset           = 1'b0;
    bus.bus_wr_en   = 1'b0;
    bus.bus_rd_en   = 1'b0;
    bus.out_ready   = 4'b0000;
    $display("reset pulse");
    check("t5_valid", 64'(bus.out_valid), 64'h0);
    check("t5_rddata", 64'(bus.bus_rd_data), 64'h0);
    load(16'hFF04);
    check("t5_status", 64'(bus.bus_rd_data), 64'h000F);
    bus.bus_addr    = 16'hFEFF;
    bus.bus_wr_data = 16'h1234;
    bus.bus_wr_en   = 1'b1;
    #1;
    check("t5_hit_below", 64'(bus.bus_hit), 64'h0);
    tick();
    bus.bus_wr_en = 1'b0;
    $display("store addr=FEFF data=1234");
    check("t5_nochange", 64'(bus.out_valid), 64'h0);
    bus.bus_addr = 16'hFF05;
    #1;
    check("t5_hit_above", 64'(bus.bus_hit), 64'h0);
    bus.bus_addr = 16'hFF04;
    #1;
    check("t5_hit_status", 64'(bus.bus_hit), 64'h1);
    store(16'hFF04, 16'hFFFF);
    check("t5_statstore", 64'(bus.out_valid), 64'h0);

    // Overflow flag set by a dropped store and cleared by a status write
    for (int i = 0; i < 9; i++) store(16'hFF00, 16'(16'h0500 + i));
    load(16'hFF04);
`ifdef MMIO_OVERFLOW_STICKY_EN
    check("t6_ovf_set", 64'(bus.bus_rd_data), 64'h011E);
`else
    check("t6_ovf_set", 64'(bus.bus_rd_data), 64'h001E);
`endif
    store(16'hFF04, 16'h0100);
    load(16'hFF04);
    check("t6_ovf_clr", 64'(bus.bus_rd_data), 64'h001E);
    bus.out_ready = 4'b0001;
    repeat (8) tick();
    bus.out_ready = 4'b0000;
    check("t6_drained", 64'(bus.out_valid), 64'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
